seven_seg_readback: RTL and testbench
=====================================

# seven_seg_readback

Sequential decoder for the six active-low seven-segment buses (HEX0–HEX5) driven by the display path. It samples all six buses every clock, waits for them to hold steady, and converts the segment patterns back into a packed BCD word with a blank mask, an update strobe and sticky error reporting. It sits beside the display drivers in the top level for on-chip self-check and bench readback, replacing ad-hoc pattern matching in testbenches.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive matching samples required before a word is accepted (≥1)
- CNT_W, 8, width of the saturating error counter

Ports:
- ADC_CLK_10  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- HEX0..HEX5  in  8 each  active-low segment buses; bit 7 = decimal point, bits 6:0 = g..a
- digits  out  24  BCD: [23:20]=HEX5, [19:16]=HEX4, [15:12]=HEX3, [11:8]=HEX2, [7:4]=HEX1, [3:0]=HEX0; blank digit reads 4'hF
- blank_mask  out  6  bit n = 1 when HEXn is blank (8'hFF)
- valid  out  1  at least one legal word accepted since reset
- update  out  1  one-cycle pulse when the accepted word changes
- err  out  1  sticky: an illegal word has been accepted
- err_count  out  CNT_W  number of illegal words accepted, saturating at all-ones

## Operation
- Legal patterns per bus: C0=0, F9=1, A4=2, B0=3, 99=4, 92=5, 82=6, F8=7, 80=8, 90=9, FF=blank. Bit 7 must be 1 (dp off); any other byte is illegal.
- in_q: 48-bit register loaded with {HEX5..HEX0} every edge. match = ({HEX5..HEX0} == in_q).
- stab_cnt: counts consecutive matching edges; cleared on any mismatch; saturates at STABLE_CYCLES.
- States:
  - SETTLE: on an edge with match, stab_cnt++. When stab_cnt == STABLE_CYCLES−1 and match, perform an accept and go to HOLD. On mismatch, stab_cnt ← 0 and remain.
  - HOLD: remain while match. On mismatch, stab_cnt ← 0 and go to SETTLE. No further accepts occur in HOLD.
- Accept, all six buses legal: load digits and blank_mask from the decode and set valid. Pulse update if the decoded {digits, blank_mask} differs from the current value, or if valid was 0.
- Accept, any bus illegal: digits, blank_mask, valid and update are unchanged. Set err, and increment err_count unless it is already all-ones.
- err and err_count clear only on reset.

## Timing
- Reset (asynchronous assert, synchronous-edge release): digits=24'h000000, blank_mask=6'b000000, valid=0, update=0, err=0, err_count=0, state=SETTLE, stab_cnt=0, in_q=48'hFFFF_FFFF_FFFF.
- Latency: if a new word is first sampled into in_q at edge E0 and holds, outputs update at edge E0+STABLE_CYCLES. update is high for exactly the following cycle.
- A change at any edge before acceptance restarts the count. A glitch shorter than STABLE_CYCLES+1 edges is never accepted.
- A reset asserted mid-settle discards the count. After release the first word needs the full STABLE_CYCLES again, and its accept always pulses update.
- Re-accepting the same legal word after a glitch is a legal accept with no update pulse.
- Outputs are registered only; there is no combinational path from the HEX inputs to any output.

## Test plan
- Reset, then hold HEX5..HEX0 = C0,F9,FF,A4,B0,99 -> after STABLE_CYCLES+1 edges: digits=24'h01F234, blank_mask=6'b001000, valid=1, a single-cycle update pulse, err=0.
- Stable word, then change HEX0 to 92 for 2 cycles and back to 99 (STABLE_CYCLES=4) -> no accept, digits still 24'h01F234, no update.
- Change HEX0 to 92 and hold -> digits=24'h01F235 exactly 4 cycles after the first sampling edge; one update pulse.
- Hold HEX2=7F (dp on) -> err=1, err_count=1, digits unchanged, no update. Repeat with 300 alternating illegal words at CNT_W=8 -> err_count saturates at 8'hFF.
- Assert reset_n low mid-settle, 2 cycles after a change -> all outputs go to their reset values immediately. After release with the same word held, the accept arrives 4 cycles later with update=1.
- Set STABLE_CYCLES=1 and change the word each cycle for 3 cycles, then hold -> only the final word is accepted, one cycle after it is first sampled.

Source files
------------

// File: rtl/seven_seg_readback.sv
// Readback decoder for six active-low seven-segment buses. Samples every clock,
// waits for the buses to hold steady, then converts the segment patterns back
// into packed BCD with a blank mask, an update strobe and sticky error reporting.
module seven_seg_readback #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             ADC_CLK_10,
    input  logic             reset_n,
    input  logic [7:0]       HEX0,
    input  logic [7:0]       HEX1,
    input  logic [7:0]       HEX2,
    input  logic [7:0]       HEX3,
    input  logic [7:0]       HEX4,
    input  logic [7:0]       HEX5,
    output logic [23:0]      digits,
    output logic [5:0]       blank_mask,
    output logic             valid,
    output logic             update,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] CntMax = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] CntAcc = SW'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {StSettle, StHold} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     stab_q, stab_d;
    logic [47:0]       in_q;
    logic [47:0]       in_w;
    logic              match;
    logic [23:0]       digits_q, digits_d;
    logic [5:0]        blank_q, blank_d;
    logic              valid_q, valid_d;
    logic              update_q, update_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [23:0]       dec_digits;
    logic [5:0]        dec_blank;
    logic              dec_legal;

    // Returns {legal, blank, bcd}; a lit decimal point makes the byte illegal.
    function automatic logic [5:0] decode(input logic [7:0] seg);
        logic [5:0] r;
        case (seg)
            8'hC0:   r = 6'b10_0000;
            8'hF9:   r = 6'b10_0001;
            8'hA4:   r = 6'b10_0010;
            8'hB0:   r = 6'b10_0011;
            8'h99:   r = 6'b10_0100;
            8'h92:   r = 6'b10_0101;
            8'h82:   r = 6'b10_0110;
            8'hF8:   r = 6'b10_0111;
            8'h80:   r = 6'b10_1000;
            8'h90:   r = 6'b10_1001;
            8'hFF:   r = 6'b11_1111;
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    assign in_w  = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    assign match = (in_w == in_q);

    // Decode the registered sample; at an accept edge it equals the live inputs.
    always_comb begin
        logic [5:0] d;
        dec_digits = '0;
        dec_blank  = '0;
        dec_legal  = 1'b1;
        d          = '0;
        for (int i = 0; i < 6; i++) begin
            d                   = decode(in_q[i*8 +: 8]);
            dec_digits[i*4 +: 4] = d[3:0];
            dec_blank[i]        = d[4];
            dec_legal           = dec_legal & d[5];
        end
    end

    // Stability counting, accept decision and output next-state.
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (!match) begin
            stab_d  = '0;
            state_d = StSettle;
        end else begin
            if (stab_q != CntMax) begin
                stab_d = stab_q + SW'(1);
            end
            if (state_q == StSettle && stab_q == CntAcc) begin
                state_d = StHold;
                if (dec_legal) begin
                    digits_d = dec_digits;
                    blank_d  = dec_blank;
                    valid_d  = 1'b1;
                    update_d = !valid_q || ({dec_digits, dec_blank} != {digits_q, blank_q});
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StSettle;
            stab_q    <= '0;
            in_q      <= 48'hFFFF_FFFF_FFFF;
            digits_q  <= '0;
            blank_q   <= '0;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            in_q      <= in_w;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign digits     = digits_q;
    assign blank_mask = blank_q;
    assign valid      = valid_q;
    assign update     = update_q;
    assign err        = err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_seven_seg_readback.sv
// Directed bench for seven_seg_readback: one instance at STABLE_CYCLES=4, one at 1.
module tb_seven_seg_readback;

    logic        clk;
    logic        rst_n;
    logic [7:0]  h0, h1, h2, h3, h4, h5;
    logic [7:0]  g0, g1, g2, g3, g4, g5;
    logic [23:0] digits4, digits1;
    logic [5:0]  mask4, mask1;
    logic        valid4, valid1, update4, update1, err4, err1;
    logic [7:0]  cnt4, cnt1;

    int n_total;
    int n_bad;
    int upd4_seen;
    int upd1_seen;
    int u0;

    seven_seg_readback #(.STABLE_CYCLES(4), .CNT_W(8)) dut4 (
        .ADC_CLK_10(clk), .reset_n(rst_n),
        .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5),
        .digits(digits4), .blank_mask(mask4), .valid(valid4), .update(update4),
        .err(err4), .err_count(cnt4)
    );

    seven_seg_readback #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .ADC_CLK_10(clk), .reset_n(rst_n),
        .HEX0(g0), .HEX1(g1), .HEX2(g2), .HEX3(g3), .HEX4(g4), .HEX5(g5),
        .digits(digits1), .blank_mask(mask1), .valid(valid1), .update(update1),
        .err(err1), .err_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles where each update strobe is high.
    always @(negedge clk) begin
        if (update4) upd4_seen <= upd4_seen + 1;
        if (update1) upd1_seen <= upd1_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Word order is HEX5..HEX0, most significant byte first.
    task automatic set_word4(input logic [47:0] w);
        {h5, h4, h3, h2, h1, h0} = w;
    endtask

    task automatic set_word1(input logic [47:0] w);
        {g5, g4, g3, g2, g1, g0} = w;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        upd4_seen = 0;
        upd1_seen = 0;
        rst_n     = 1'b0;
        set_word4(48'hFFFF_FFFF_FFFF);
        set_word1(48'hFFFF_FFFF_FFFF);
        tick(2);
        check("rst_digits", 64'(digits4), 64'h0);
        check("rst_mask",   64'(mask4),   64'h0);
        check("rst_valid",  64'(valid4),  64'h0);
        check("rst_update", 64'(update4), 64'h0);
        check("rst_err",    64'(err4),    64'h0);
        check("rst_cnt",    64'(cnt4),    64'h0);

        // First word: 0,1,blank,2,3,4.
        rst_n = 1'b1;
        set_word4(48'hC0F9_FFA4_B099);
        tick(1);
        check("first_e0_valid", 64'(valid4), 64'h0);
        tick(3);
        check("first_e3_valid", 64'(valid4), 64'h0);
        tick(1);
        check("first_digits", 64'(digits4), 64'h01F234);
        check("first_mask",   64'(mask4),   64'b001000);
        check("first_valid",  64'(valid4),  64'h1);
        check("first_update", 64'(update4), 64'h1);
        check("first_err",    64'(err4),    64'h0);
        tick(1);
        check("first_upd_drop", 64'(update4), 64'h0);

        // Two-cycle glitch on HEX0 is rejected; same word re-accepted silently.
        u0 = upd4_seen;
        h0 = 8'h92;
        tick(2);
        h0 = 8'h99;
        tick(8);
        check("glitch_digits", 64'(digits4), 64'h01F234);
        check("glitch_updates", 64'(upd4_seen - u0), 64'h0);

        // Held change accepted exactly four edges after first sampling.
        h0 = 8'h92;
        tick(4);
        check("chg_e3_digits", 64'(digits4), 64'h01F234);
        tick(1);
        check("chg_digits", 64'(digits4), 64'h01F235);
        check("chg_update", 64'(update4), 64'h1);
        tick(1);
        check("chg_upd_drop", 64'(update4), 64'h0);

        // Decimal point lit on HEX2 is illegal.
        u0 = upd4_seen;
        h2 = 8'h7F;
        tick(5);
        check("ill_err",    64'(err4),    64'h1);
        check("ill_cnt",    64'(cnt4),    64'h1);
        check("ill_digits", 64'(digits4), 64'h01F235);
        tick(1);
        check("ill_updates", 64'(upd4_seen - u0), 64'h0);

        for (int i = 0; i < 300; i++) begin
            h2 = (i % 2 == 0) ? 8'h7E : 8'h7F;
            tick(5);
            if (i == 9) check("ill_cnt11", 64'(cnt4), 64'd11);
        end
        check("sat_cnt",    64'(cnt4),    64'hFF);
        check("sat_err",    64'(err4),    64'h1);
        check("sat_digits", 64'(digits4), 64'h01F235);
        check("sat_valid",  64'(valid4),  64'h1);

        // Reset mid-settle clears everything at once.
        h2 = 8'hA4;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_digits", 64'(digits4), 64'h0);
        check("mid_rst_valid",  64'(valid4),  64'h0);
        check("mid_rst_err",    64'(err4),    64'h0);
        check("mid_rst_cnt",    64'(cnt4),    64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("post_rst_e3_valid", 64'(valid4), 64'h0);
        tick(1);
        check("post_rst_valid",  64'(valid4),  64'h1);
        check("post_rst_digits", 64'(digits4), 64'h01F235);
        check("post_rst_update", 64'(update4), 64'h1);

        // STABLE_CYCLES=1: only the final held word is accepted.
        u0 = upd1_seen;
        set_word1(48'hC0F9_A4B0_9992);
        tick(1);
        set_word1(48'h82F8_8090_C0F9);
        tick(1);
        set_word1(48'h8090_F882_9299);
        tick(1);
        check("s1_digits_blank", 64'(digits1), 64'hFFFFFF);
        tick(1);
        check("s1_digits", 64'(digits1), 64'h897654);
        check("s1_mask",   64'(mask1),   64'h0);
        check("s1_update", 64'(update1), 64'h1);
        tick(2);
        check("s1_updates", 64'(upd1_seen - u0), 64'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
